// File: rtl/sd_add_sequencer.sv
// Feeds DIGITS-wide signed-digit operands through an external 3-operand 4-digit adder,
// one chunk per cycle, and holds the assembled result. Optional ovf: SDSEQ_OVF_CHECK_EN.
module sd_add_sequencer #(
    parameter int unsigned DIGITS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIGITS-1:0] x_plus,
    input  logic [DIGITS-1:0] x_minus,
    input  logic [DIGITS-1:0] y_plus,
    input  logic [DIGITS-1:0] y_minus,
    input  logic [DIGITS-1:0] r_plus,
    input  logic [DIGITS-1:0] r_minus,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DIGITS-1:0] sum_plus,
    output logic [DIGITS-1:0] sum_minus,
    output logic [1:0]        cout_one_final,
    output logic [1:0]        cout_two_final,
    output logic [3:0]        add_x_plus,
    output logic [3:0]        add_x_minus,
    output logic [3:0]        add_y_plus,
    output logic [3:0]        add_y_minus,
    output logic [3:0]        add_r_plus,
    output logic [3:0]        add_r_minus,
    output logic [1:0]        add_cin_one,
    output logic [1:0]        add_cin_two,
    input  logic [3:0]        add_res_plus,
    input  logic [3:0]        add_res_minus,
    input  logic [1:0]        add_cout_one,
    input  logic [1:0]        add_cout_two
`ifdef SDSEQ_OVF_CHECK_EN
    ,
    output logic              ovf
`endif
);

    localparam int unsigned NCHUNK = DIGITS / 4;
    localparam int unsigned KWidth = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

    state_e              state_q, state_d;
    logic [KWidth-1:0]   k_q, k_d;
    logic [DIGITS-1:0]   xp_q, xm_q, yp_q, ym_q, rp_q, rm_q;
    logic [DIGITS-1:0]   xp_d, xm_d, yp_d, ym_d, rp_d, rm_d;
    logic [DIGITS-1:0]   sum_p_q, sum_m_q, sum_p_d, sum_m_d;
    logic [1:0]          c1_q, c2_q, c1_d, c2_d;
    logic [1:0]          f1_q, f2_q, f1_d, f2_d;
`ifdef SDSEQ_OVF_CHECK_EN
    logic                ovf_q, ovf_d;
`endif

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        xp_d        = xp_q;
        xm_d        = xm_q;
        yp_d        = yp_q;
        ym_d        = ym_q;
        rp_d        = rp_q;
        rm_d        = rm_q;
        sum_p_d     = sum_p_q;
        sum_m_d     = sum_m_q;
        c1_d        = c1_q;
        c2_d        = c2_q;
        f1_d        = f1_q;
        f2_d        = f2_q;
`ifdef SDSEQ_OVF_CHECK_EN
        ovf_d       = ovf_q;
`endif
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        add_x_plus  = 4'b0;
        add_x_minus = 4'b0;
        add_y_plus  = 4'b0;
        add_y_minus = 4'b0;
        add_r_plus  = 4'b0;
        add_r_minus = 4'b0;
        add_cin_one = 2'b00;
        add_cin_two = 2'b00;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    xp_d    = x_plus;
                    xm_d    = x_minus;
                    yp_d    = y_plus;
                    ym_d    = y_minus;
                    rp_d    = r_plus;
                    rm_d    = r_minus;
                    k_d     = '0;
                    state_d = StRun;
`ifdef SDSEQ_OVF_CHECK_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            StRun: begin
                // Constant-base chunk mux; the adder answers in the same cycle.
                for (int c = 0; c < NCHUNK; c++) begin
                    if (k_q == KWidth'(c)) begin
                        add_x_plus          = xp_q[4*c +: 4];
                        add_x_minus         = xm_q[4*c +: 4];
                        add_y_plus          = yp_q[4*c +: 4];
                        add_y_minus         = ym_q[4*c +: 4];
                        add_r_plus          = rp_q[4*c +: 4];
                        add_r_minus         = rm_q[4*c +: 4];
                        sum_p_d[4*c +: 4]   = add_res_plus;
                        sum_m_d[4*c +: 4]   = add_res_minus;
                    end
                end
                if (k_q != '0) begin
                    add_cin_one = c1_q;
                    add_cin_two = c2_q;
                end
                c1_d = add_cout_one;
                c2_d = add_cout_two;
                if (k_q == KWidth'(NCHUNK - 1)) begin
                    k_d     = '0;
                    f1_d    = add_cout_one;
                    f2_d    = add_cout_two;
                    state_d = StHold;
`ifdef SDSEQ_OVF_CHECK_EN
                    ovf_d   = |{add_cout_one, add_cout_two};
`endif
                end else begin
                    k_d = k_q + KWidth'(1);
                end
            end
            StHold: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            k_q     <= '0;
            xp_q    <= '0;
            xm_q    <= '0;
            yp_q    <= '0;
            ym_q    <= '0;
            rp_q    <= '0;
            rm_q    <= '0;
            sum_p_q <= '0;
            sum_m_q <= '0;
            c1_q    <= 2'b00;
            c2_q    <= 2'b00;
            f1_q    <= 2'b00;
            f2_q    <= 2'b00;
`ifdef SDSEQ_OVF_CHECK_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            xp_q    <= xp_d;
            xm_q    <= xm_d;
            yp_q    <= yp_d;
            ym_q    <= ym_d;
            rp_q    <= rp_d;
            rm_q    <= rm_d;
            sum_p_q <= sum_p_d;
            sum_m_q <= sum_m_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            f1_q    <= f1_d;
            f2_q    <= f2_d;
`ifdef SDSEQ_OVF_CHECK_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum_plus       = sum_p_q;
    assign sum_minus      = sum_m_q;
    assign cout_one_final = f1_q;
    assign cout_two_final = f2_q;
`ifdef SDSEQ_OVF_CHECK_EN
    assign ovf            = ovf_q;
`endif

endmodule
